// File: rtl/wb_arbiter_2to1_pkg.sv
// Shared types and constants for the 2:1 Wishbone arbiter.
package wb_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    GRANT_FETCH = 2'd1,
    GRANT_MEM   = 2'd2
  } wb_arb_state_e;

  localparam logic OWNER_FETCH = 1'b0;
  localparam logic OWNER_MEM   = 1'b1;

  // One-hot owner vector for a state: bit0 = fetch, bit1 = mem.
  function automatic logic [1:0] state_to_grant(wb_arb_state_e s);
    state_to_grant = {s == GRANT_MEM, s == GRANT_FETCH};
  endfunction

endpackage

// File: rtl/wb_arbiter_2to1_if.sv
// Classic single-beat Wishbone bundle; master drives the request, slave the response.
interface wb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [ADDR_WIDTH-1:0] adr;
  logic [SEL_WIDTH-1:0]  sel;
  logic [DATA_WIDTH-1:0] dat_mosi;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] dat_miso;

  modport master (
    output cyc, stb, we, adr, sel, dat_mosi,
    input  ack, err, dat_miso
  );

  modport slave (
    input  cyc, stb, we, adr, sel, dat_mosi,
    output ack, err, dat_miso
  );
endinterface

// File: rtl/wb_arbiter_2to1_timeout.sv
// Per-access watchdog: counts stalled strobe cycles, flags when LIMIT is reached.
module wb_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  if (LIMIT == 0) begin : g_off
    // Watchdog disabled: never expires.
    logic unused_in;
    assign unused_in = ^{clk, rst, clear, count_en};
    assign expired   = 1'b0;
  end else begin : g_on
    localparam int             CW  = $clog2(LIMIT + 1);
    localparam logic [CW-1:0]  LIM = CW'(LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LIM);

    // Saturating count; clears on request or once the limit has fired.
    always_comb begin
      cnt_d = cnt_q;
      if (clear || expired)
        cnt_d = '0;
      else if (count_en && (cnt_q != LIM))
        cnt_d = cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_2to1.sv
// Round-robin 2:1 Wishbone arbiter (fetch vs. mem) with cycle-locked ownership
// and a watchdog that turns a hung slave into an err to the owner.
module wb_arbiter_2to1
  import wb_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       rst,
  wb_if.slave        fetch,
  wb_if.slave        mem,
  wb_if.master       bus,
  output logic [1:0] grant
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;

  wb_arb_state_e state_q, state_d;
  logic          last_owner_q, last_owner_d;

  logic                  own_cyc, own_stb, own_we;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [SEL_WIDTH-1:0]  own_sel;
  logic [DATA_WIDTH-1:0] own_dat;
  logic                  expired;
  logic                  rsp_ack, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_dat;

  // Next-state: round-robin from IDLE, hold while owner cyc, direct handover.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (fetch.cyc && mem.cyc)
          state_d = (last_owner_q == OWNER_MEM) ? GRANT_FETCH : GRANT_MEM;
        else if (fetch.cyc)
          state_d = GRANT_FETCH;
        else if (mem.cyc)
          state_d = GRANT_MEM;
      end
      GRANT_FETCH: if (!fetch.cyc) state_d = mem.cyc   ? GRANT_MEM   : IDLE;
      GRANT_MEM:   if (!mem.cyc)   state_d = fetch.cyc ? GRANT_FETCH : IDLE;
      default:     state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == GRANT_FETCH) last_owner_d = OWNER_FETCH;
      if (state_d == GRANT_MEM)   last_owner_d = OWNER_MEM;
    end
  end

  // FSM and last-owner registers; fetch wins the first contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_MEM;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Select the owner's request; everything is zero in IDLE.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    own_we  = 1'b0;
    own_adr = '0;
    own_sel = '0;
    own_dat = '0;
    unique case (state_q)
      GRANT_FETCH: begin
        own_cyc = fetch.cyc;
        own_stb = fetch.stb;
        own_we  = fetch.we;
        own_adr = fetch.adr;
        own_sel = fetch.sel;
        own_dat = fetch.dat_mosi;
      end
      GRANT_MEM: begin
        own_cyc = mem.cyc;
        own_stb = mem.stb;
        own_we  = mem.we;
        own_adr = mem.adr;
        own_sel = mem.sel;
        own_dat = mem.dat_mosi;
      end
      default: ;
    endcase
  end

  // Watchdog: restarts on state change, on any response, or when strobe drops.
  wb_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clear    ((state_d != state_q) || !own_stb || bus.ack || bus.err),
    .count_en (own_stb && !bus.ack && !bus.err),
    .expired  (expired)
  );

  // On expiry the access is pulled off the bus so the slave sees it abandoned.
  assign bus.cyc      = own_cyc && !expired;
  assign bus.stb      = own_stb && !expired;
  assign bus.we       = own_we;
  assign bus.adr      = own_adr;
  assign bus.sel      = own_sel;
  assign bus.dat_mosi = own_dat;

  // Response back to the owner; a real ack beats a simultaneous timeout.
  assign rsp_ack = (state_q != IDLE) && bus.ack;
  assign rsp_err = (state_q != IDLE) && (bus.err || (expired && !bus.ack));
  assign rsp_dat = (state_q != IDLE) ? bus.dat_miso : '0;

  assign fetch.ack      = (state_q == GRANT_FETCH) && rsp_ack;
  assign fetch.err      = (state_q == GRANT_FETCH) && rsp_err;
  assign fetch.dat_miso = (state_q == GRANT_FETCH) ? rsp_dat : '0;
  assign mem.ack        = (state_q == GRANT_MEM) && rsp_ack;
  assign mem.err        = (state_q == GRANT_MEM) && rsp_err;
  assign mem.dat_miso   = (state_q == GRANT_MEM) ? rsp_dat : '0;

  assign grant = state_to_grant(state_q);

endmodule
